scrambler_frame_ctrl: RTL and testbench

//  Frame sequencer for the additive bit scrambler on the serial TX path.
//  - Emits an unscrambled SYNC_WORD preamble, then a payload of PAYLOAD_LEN bits routed through the scrambler.
//  - Reseeds the scrambler (scr_set) exactly once per frame.
//  - Sits between the bit source (valid/ready) and the line-side serializer (valid/ready).

---
 rtl/scrambler_frame_ctrl.sv | 114 +++++++++++
 tb/tb_scrambler_frame_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/scrambler_frame_ctrl.sv
// Frame sequencer for the additive bit scrambler on the serial TX path.
// Each frame is an unscrambled sync preamble (MSB first) followed by a payload
// passed combinationally through the external scrambler. The scrambler is
// reseeded on the last preamble bit, so the first payload bit uses the seed key.
module scrambler_frame_ctrl #(
  parameter int          SYNC_LEN    = 16,
  parameter logic [31:0] SYNC_WORD   = 32'hF628,
  parameter int          PAYLOAD_LEN = 1024,
  parameter int          FCNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              en,
  input  logic              s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              scr_set,
  output logic              scr_adv,
  output logic              scr_in,
  input  logic              scr_out,
  output logic              m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_cnt
);

  // state   | meaning
  // IDLE    | no frame in progress; waiting for en
  // SYNC    | sending preamble bits, scrambler bypassed
  // PAYLOAD | source bits pass through the scrambler to the line
  typedef enum logic [1:0] {IDLE, SYNC, PAYLOAD} state_t;

  localparam int CNT_MAX = (SYNC_LEN > PAYLOAD_LEN) ? SYNC_LEN : PAYLOAD_LEN;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] PAY_LAST  = CNT_W'(PAYLOAD_LEN - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [4:0]          sync_idx;

  // Preamble bit index; only meaningful in SYNC where bit_cnt < SYNC_LEN.
  assign sync_idx  = 5'(SYNC_LEN - 1 - int'(bit_cnt_q));
  assign frame_cnt = frame_cnt_q;

  // State, bit counter and frame counter registers; reset aborts any frame.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Next-state and output decode; all outputs are 0 in IDLE (and thus in reset).
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;
    s_ready     = 1'b0;
    scr_set     = 1'b0;
    scr_adv     = 1'b0;
    scr_in      = 1'b0;
    m_data      = 1'b0;
    m_valid     = 1'b0;
    frame_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d   = SYNC;
          bit_cnt_d = '0;
        end
      end
      SYNC: begin
        m_valid     = 1'b1;
        m_data      = SYNC_WORD[sync_idx];
        frame_start = m_ready && (bit_cnt_q == '0);
        if (m_ready) begin
          if (bit_cnt_q == SYNC_LAST) begin
            scr_set   = 1'b1;
            bit_cnt_d = '0;
            state_d   = PAYLOAD;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      PAYLOAD: begin
        m_valid = s_valid;
        s_ready = m_ready;
        scr_in  = s_data;
        m_data  = scr_out;
        scr_adv = s_valid && m_ready;
        if (s_valid && m_ready) begin
          if (bit_cnt_q == PAY_LAST) begin
            frame_cnt_d = frame_cnt_q + FCNT_W'(1);
            bit_cnt_d   = '0;
            state_d     = en ? SYNC : IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_scrambler_frame_ctrl.sv
// Bench for scrambler_frame_ctrl: 16-bit F628 preamble, 8-bit payload,
// 2-bit frame counter, with a small 8-bit LFSR standing in for the scrambler.
module tb_scrambler_frame_ctrl;

  localparam int FRM = 24;  // 16 preamble + 8 payload bits per frame

  logic       clk = 1'b0;
  logic       rst_, en, s_data, s_valid, s_ready;
  logic       scr_set, scr_adv, scr_in, scr_out;
  logic       m_data, m_valid, m_ready, frame_start;
  logic [1:0] frame_cnt;
  logic [7:0] key = 8'h00;

  int n_pass = 0;
  int n_total = 0;

  logic [15:0] sync_v = 16'hF628;
  logic [63:0] src_v  = 64'h9C3A_5E71_D20B_48F6;
  logic        src [64];

  typedef struct {
    logic en, s_valid, s_data, m_ready;
    logic e_mvalid, e_mdata, e_sready, e_set, e_adv, e_fs;
    logic [1:0] e_fc;
  } vec_t;
  vec_t vecs [26];

  always #5 clk = ~clk;

  scrambler_frame_ctrl #(
    .SYNC_LEN(16), .SYNC_WORD(32'hF628), .PAYLOAD_LEN(8), .FCNT_W(2)
  ) dut (
    .clk(clk), .rst_(rst_), .en(en), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .scr_set(scr_set), .scr_adv(scr_adv), .scr_in(scr_in),
    .scr_out(scr_out), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  function automatic logic [7:0] lfsr_step(input logic [7:0] k);
    return {k[0] ^ k[2] ^ k[3] ^ k[4], k[7:1]};
  endfunction

  function automatic logic key_bit(input int i);
    logic [7:0] k = 8'hA5;
    for (int j = 0; j < i; j++) k = lfsr_step(k);
    return k[0];
  endfunction

  // scrambler model: reseed on scr_set, step on scr_adv
  always_ff @(posedge clk) begin
    if (scr_set) key <= 8'hA5;
    else if (scr_adv) key <= lfsr_step(key);
  end
  assign scr_out = scr_in ^ key[0];

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0b expected %0b", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ = 1'b0; en = 1'b0; s_valid = 1'b0; s_data = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
  endtask

  // Runs nframes frames and checks line bits, strobes, counters and gaps.
  task automatic run_frames(input int nframes, input bit bp, input int gap_at,
                            input int gap_len, input int exp_gaps, input int fc_base,
                            input string name);
    int tx = 0, sidx = 0, gap_used = 0, gaps = 0, cyc = 0;
    int seq_err = 0, strb_err = 0, fc_err = 0, sets = 0, advs = 0;
    int total = nframes * FRM;
    int pos, fr;
    bit gap_act, xfer;
    logic exp_b;
    while (tx < total && cyc < 2000) begin
      @(negedge clk);
      en      = (tx == 0) || (tx < (nframes - 1) * FRM);
      m_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      gap_act = (tx == gap_at) && (gap_used < gap_len);
      if (gap_act) gap_used++;
      s_valid = !gap_act;
      s_data  = src[sidx % 64];
      #1;
      pos  = tx % FRM;
      fr   = tx / FRM;
      xfer = m_valid && m_ready;
      if (tx > 0 && !m_valid) gaps++;
      if (scr_adv !== (xfer && pos >= 16)) strb_err++;
      if (scr_set !== (xfer && pos == 15)) strb_err++;
      if (frame_start !== (xfer && pos == 0)) strb_err++;
      if (s_ready !== ((pos >= 16) ? m_ready : 1'b0)) strb_err++;
      if (xfer) begin
        if (pos < 16) exp_b = sync_v[15 - pos];
        else exp_b = src[(fr * 8 + pos - 16) % 64] ^ key_bit(pos - 16);
        if (m_data !== exp_b) seq_err++;
        if (pos == 0 && frame_cnt !== 2'((fc_base + fr) % 4)) fc_err++;
        tx++;
      end
      if (s_valid && s_ready) sidx++;
      sets += int'(scr_set);
      advs += int'(scr_adv);
      cyc++;
    end
    check(tx == total, {name, "_done"}, tx, total);
    check(seq_err == 0, {name, "_bits"}, seq_err, 0);
    check(strb_err == 0, {name, "_strobes"}, strb_err, 0);
    check(fc_err == 0, {name, "_fc_at_start"}, fc_err, 0);
    check(sets == nframes, {name, "_scr_set_cnt"}, sets, nframes);
    check(advs == nframes * 8, {name, "_scr_adv_cnt"}, advs, nframes * 8);
    check(gaps == exp_gaps, {name, "_gap_cycles"}, gaps, exp_gaps);
    @(negedge clk);
    en = 1'b0;
    #1;
    check({m_valid, frame_cnt} === {1'b0, 2'((fc_base + nframes) % 4)}, {name, "_end"},
          {m_valid, frame_cnt}, {1'b0, 2'((fc_base + nframes) % 4)});
  endtask

  initial begin
    for (int i = 0; i < 64; i++) src[i] = src_v[i];

    // one-frame table: IDLE with en pulse, 16 preamble bits, 8 payload bits, back to IDLE
    vecs[0] = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd0};
    for (int i = 0; i < 16; i++)
      vecs[1 + i] = '{0, 0, 0, 1, 1, sync_v[15 - i], 0, (i == 15), 0, (i == 0), 2'd0};
    for (int p = 0; p < 8; p++)
      vecs[17 + p] = '{0, 1, src[p], 1, 1, src[p] ^ key_bit(p), 1, 0, 1, 0, 2'd0};
    vecs[25] = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'd1};

    // T1: reset and idle
    rst_ = 1'b0; en = 1'b0; s_valid = 1'b0; s_data = 1'b0; m_ready = 1'b1;
    #12;
    check({m_valid, m_data, s_ready, scr_set, scr_adv, scr_in, frame_start, frame_cnt} === 9'b0,
          "t1_in_reset", {m_valid, m_data, s_ready, scr_set, scr_adv, scr_in, frame_start, frame_cnt}, 0);
    @(negedge clk);
    rst_ = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      check({m_valid, s_ready, frame_cnt} === 4'b0, $sformatf("t1_idle%0d", i),
            {m_valid, s_ready, frame_cnt}, 0);
    end

    // T2: table-driven single frame
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      en = vecs[i].en; s_valid = vecs[i].s_valid; s_data = vecs[i].s_data; m_ready = vecs[i].m_ready;
      #1;
      check({m_valid, m_data, s_ready, scr_set, scr_adv, frame_start, frame_cnt} ===
            {vecs[i].e_mvalid, vecs[i].e_mdata, vecs[i].e_sready, vecs[i].e_set,
             vecs[i].e_adv, vecs[i].e_fs, vecs[i].e_fc},
            $sformatf("t2_vec%0d", i),
            {m_valid, m_data, s_ready, scr_set, scr_adv, frame_start, frame_cnt},
            {vecs[i].e_mvalid, vecs[i].e_mdata, vecs[i].e_sready, vecs[i].e_set,
             vecs[i].e_adv, vecs[i].e_fs, vecs[i].e_fc});
    end

    // T3: line backpressure 1,0,0,1,...
    run_frames(1, 1'b1, -1, 0, 0, 1, "t3");
    // T4: source starved for 5 cycles at payload bit 4
    run_frames(1, 1'b0, 20, 5, 5, 2, "t4");

    // T6: reset at payload bit 4 aborts the frame
    @(negedge clk);
    en = 1'b1; m_ready = 1'b1; s_valid = 1'b1; s_data = 1'b0;
    repeat (21) @(negedge clk);
    #1;
    check({m_valid, s_ready, scr_adv} === 3'b111, "t6_in_payload", {m_valid, s_ready, scr_adv}, 3'b111);
    rst_ = 1'b0;
    #1;
    check({m_valid, m_data, s_ready, scr_set, scr_adv, scr_in, frame_start, frame_cnt} === 9'b0,
          "t6_async_clear", {m_valid, m_data, s_ready, scr_set, scr_adv, scr_in, frame_start, frame_cnt}, 0);
    @(negedge clk);
    rst_ = 1'b1;
    run_frames(1, 1'b0, -1, 0, 0, 0, "t6_refr");

    // T5: continuous frames with counter wrap on the fourth
    do_reset();
    run_frames(4, 1'b0, -1, 0, 0, 0, "t5");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
